// File: rtl/tft_fb_pkg.sv
// rtl/tft_fb_pkg.sv - frame geometry, clear value and FSM state encoding for the frame-buffer arbiter
package tft_fb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_CLEAR = 2'd2
  } fb_state_t;

  localparam int FB_W = 480;
  localparam int FB_H = 272;
  localparam int FB_DEPTH = FB_W * FB_H;
  localparam logic [15:0] CLR_VALUE = 16'h0000;

endpackage

// File: rtl/tft_fb_wr_fifo.sv
// rtl/tft_fb_wr_fifo.sv - synchronous {addr, data} FIFO buffering UART pixel writes
module tft_fb_wr_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                     CLK_33M,
  input  logic                     Reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge CLK_33M or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge CLK_33M) begin
    if (push && !full)
      store[wr_ptr[AW-1:0]] <= push_data;
  end

  assign count    = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (count == (AW+1)'(DEPTH));
  assign pop_data = store[rd_ptr[AW-1:0]];

endmodule

// File: rtl/tft_fb_arbiter.sv
// rtl/tft_fb_arbiter.sv - single-port frame-buffer arbiter: display reads, buffered UART writes, clear engine (option TFT_FB_STATS_EN)
module tft_fb_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 16,
  parameter int FB_DEPTH   = tft_fb_pkg::FB_DEPTH,
  parameter int FIFO_DEPTH = 4,
  parameter logic [DATA_W-1:0] CLR_VALUE = tft_fb_pkg::CLR_VALUE
) (
  input  logic              CLK_33M,
  input  logic              Reset_n,
  input  logic              frame_start,
  input  logic              rd_pre,
  output logic [DATA_W-1:0] pix_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic [15:0]       stall_cnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  import tft_fb_pkg::*;

  localparam int FW = ADDR_W + DATA_W;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

  fb_state_t         state;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] clr_addr;
  logic              rd_vld_d1;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [FW-1:0]     head;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              fifo_busy_next;

  tft_fb_wr_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .CLK_33M   (CLK_33M),
    .Reset_n   (Reset_n),
    .push      (push),
    .push_data ({wr_addr, wr_data}),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign {head_addr, head_data} = head;
  assign wr_ready = !fifo_full;
  assign push     = wr_valid && !fifo_full;
  // Draining starts straight from idle so a buffered write never waits an extra cycle.
  assign pop      = !rd_pre && !fifo_empty && !clr_req && (state != S_CLEAR);
  assign fifo_busy_next = push || (fifo_count > CW'(pop));
  assign pix_data = rd_vld_d1 ? mem_rdata : '0;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rd_pre) begin
      mem_en   = 1'b1;
      mem_addr = rd_addr;
    end else if (state == S_CLEAR) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = clr_addr;
      mem_wdata = CLR_VALUE;
    end else if (pop && (head_addr <= LAST_ADDR)) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = head_addr;
      mem_wdata = head_data;
    end
  end

  always_ff @(posedge CLK_33M or negedge Reset_n) begin
    if (!Reset_n) begin
      rd_addr   <= '0;
      rd_vld_d1 <= 1'b0;
    end else begin
      rd_vld_d1 <= rd_pre;
      if (frame_start)
        rd_addr <= '0;
      else if (rd_pre)
        rd_addr <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + 1'b1;
    end
  end

  // A clear request is taken even in a read cycle; everything else waits for a free slot.
  always_ff @(posedge CLK_33M or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= S_IDLE;
      clr_addr <= '0;
      clr_busy <= 1'b0;
    end else if (clr_req && (state != S_CLEAR)) begin
      state    <= S_CLEAR;
      clr_addr <= '0;
      clr_busy <= 1'b1;
    end else if (!rd_pre) begin
      case (state)
        S_IDLE, S_WRITE: state <= fifo_busy_next ? S_WRITE : S_IDLE;
        S_CLEAR: begin
          if (clr_addr == LAST_ADDR) begin
            state    <= fifo_busy_next ? S_WRITE : S_IDLE;
            clr_busy <= 1'b0;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef TFT_FB_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge CLK_33M or negedge Reset_n) begin
    if (!Reset_n)
      stall_q <= '0;
    else if (wr_valid && !wr_ready && (stall_q != 16'hFFFF))
      stall_q <= stall_q + 1'b1;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_tft_fb_arbiter.sv
// tb/tb_tft_fb_arbiter.sv - self-checking bench for tft_fb_arbiter with a scoreboard and RAM model
module tb_tft_fb_arbiter;

  localparam int TB_DEPTH = 960;
`ifdef TFT_FB_STATS_EN
  localparam logic [15:0] EXP_STALL = 16'd476;
`else
  localparam logic [15:0] EXP_STALL = 16'd0;
`endif

  logic        clk = 1'b0;
  logic        Reset_n;
  logic        frame_start, rd_pre, wr_valid, clr_req;
  logic [16:0] wr_addr;
  logic [15:0] wr_data;
  logic [15:0] pix_data, stall_cnt, mem_wdata;
  logic        wr_ready, clr_busy, mem_en, mem_we;
  logic [16:0] mem_addr;
  logic [15:0] mem_rdata;
  logic [15:0] ram [0:131071];

  int          vectors = 0;
  int          miscompares = 0;
  bit          mon_on = 0, chk_pix = 0, prev_rd = 0, exp_clr_active = 0;
  logic [16:0] exp_rd_addr = '0;
  logic [16:0] exp_clr_addr = '0;
  logic [15:0] rd_q [$];
  logic [32:0] wr_q [$];

  always #15 clk = ~clk;

  tft_fb_arbiter #(.FB_DEPTH(TB_DEPTH)) dut (
    .CLK_33M(clk), .Reset_n(Reset_n), .frame_start(frame_start), .rd_pre(rd_pre),
    .pix_data(pix_data), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .clr_req(clr_req), .clr_busy(clr_busy), .stall_cnt(stall_cnt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial for (int a = 0; a < 131072; a++) ram[a] = a[15:0];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  // Scoreboard monitor: expectations are pushed as stimulus is seen, popped as the DUT responds.
  always @(negedge clk) begin
    logic [15:0] ep;
    logic [32:0] ew;
    if (Reset_n && mon_on) begin
      if (prev_rd) begin
        if (rd_q.size() > 0) begin
          ep = rd_q.pop_front();
          vectors++;
          if (pix_data !== ep) begin
            miscompares++;
            $display("FAIL pix_data: got %h expected %h", pix_data, ep);
          end
        end
      end else if (chk_pix) begin
        vectors++;
        if (pix_data !== 16'h0) begin
          miscompares++;
          $display("FAIL pix_idle: got %h expected 0000", pix_data);
        end
      end
      if (rd_pre) begin
        vectors++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== exp_rd_addr) begin
          miscompares++;
          $display("FAIL read_slot: en=%b we=%b addr=%0d expected en=1 we=0 addr=%0d", mem_en, mem_we, mem_addr, exp_rd_addr);
        end
        if (chk_pix) rd_q.push_back(exp_rd_addr[15:0]);
      end else if (mem_we === 1'b1) begin
        vectors++;
        if (exp_clr_active) begin
          if (mem_addr !== exp_clr_addr || mem_wdata !== 16'h0000) begin
            miscompares++;
            $display("FAIL clear_write: addr=%0d data=%h expected addr=%0d data=0000", mem_addr, mem_wdata, exp_clr_addr);
          end
          if (exp_clr_addr == 17'(TB_DEPTH - 1)) exp_clr_active = 0;
          else exp_clr_addr = exp_clr_addr + 1'b1;
        end else if (wr_q.size() > 0) begin
          ew = wr_q.pop_front();
          if ({mem_addr, mem_wdata} !== ew) begin
            miscompares++;
            $display("FAIL fifo_write: addr=%0d data=%h expected addr=%0d data=%h", mem_addr, mem_wdata, ew[32:16], ew[15:0]);
          end
        end else begin
          miscompares++;
          $display("FAIL unexpected_write: addr=%0d data=%h expected no write", mem_addr, mem_wdata);
        end
      end else if (mem_en === 1'b1) begin
        vectors++;
        miscompares++;
        $display("FAIL stray_access: mem_en=1 addr=%0d expected mem_en=0", mem_addr);
      end
      if (wr_valid && wr_ready && (wr_addr < 17'(TB_DEPTH))) wr_q.push_back({wr_addr, wr_data});
      if (frame_start) exp_rd_addr = '0;
      else if (rd_pre) exp_rd_addr = (exp_rd_addr == 17'(TB_DEPTH - 1)) ? '0 : exp_rd_addr + 1'b1;
      prev_rd = rd_pre;
    end
  end

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic sample_point();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    frame_start = 0; rd_pre = 0; wr_valid = 0; clr_req = 0; wr_addr = '0; wr_data = '0;
  endtask

  task automatic flush_model();
    rd_q.delete(); wr_q.delete();
    prev_rd = 0; exp_rd_addr = '0; exp_clr_active = 0; exp_clr_addr = '0;
  endtask

  task automatic test_reset();
    Reset_n = 0; idle_inputs(); mon_on = 0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({pix_data, clr_busy, mem_en, mem_we, mem_addr, mem_wdata, stall_cnt} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: pix=%h busy=%b en=%b we=%b addr=%0d wdata=%h stall=%0d expected all 0",
               pix_data, clr_busy, mem_en, mem_we, mem_addr, mem_wdata, stall_cnt);
    end
    Reset_n = 1;
    flush_model();
    sample_point();
    vectors++;
    if (wr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_wr_ready: got %b expected 1", wr_ready);
    end
    mon_on = 1;
  endtask

  task automatic test_read_burst();
    chk_pix = 1;
    for (int i = 0; i < 480; i++) begin
      drive_edge(); rd_pre = 1;
      sample_point();
      vectors++;
      if (mem_addr !== 17'(i)) begin
        miscompares++;
        $display("FAIL burst_addr: got %0d expected %0d", mem_addr, i);
      end
    end
    drive_edge(); rd_pre = 0;
    repeat (3) drive_edge();
  endtask

  task automatic test_wrap_and_frame_start();
    int n;
    n = TB_DEPTH - 480 + 5;
    for (int j = 0; j < n; j++) begin
      drive_edge(); rd_pre = 1;
      sample_point();
      vectors++;
      if (mem_addr !== 17'((480 + j) % TB_DEPTH)) begin
        miscompares++;
        $display("FAIL wrap_addr: got %0d expected %0d", mem_addr, (480 + j) % TB_DEPTH);
      end
    end
    drive_edge(); rd_pre = 1; frame_start = 1;
    drive_edge(); frame_start = 0;
    sample_point();
    vectors++;
    if (mem_addr !== 17'd0 || mem_en !== 1'b1) begin
      miscompares++;
      $display("FAIL frame_start_addr: got %0d en=%b expected 0 en=1", mem_addr, mem_en);
    end
    drive_edge(); rd_pre = 0;
    repeat (2) drive_edge();
    chk_pix = 0;
  endtask

  task automatic test_write_stall();
    int accepts = 0;
    for (int i = 0; i < 480; i++) begin
      drive_edge(); rd_pre = 1; wr_valid = 1; wr_addr = 17'd5; wr_data = 16'hABCD;
      sample_point();
      vectors++;
      if (wr_ready !== (i < 4)) begin
        miscompares++;
        $display("FAIL stall_ready: cycle %0d got %b expected %b", i, wr_ready, (i < 4));
      end
      if (wr_ready === 1'b1) accepts++;
    end
    drive_edge(); rd_pre = 0; wr_valid = 0;
    vectors++;
    if (accepts != 4) begin
      miscompares++;
      $display("FAIL stall_accepts: got %0d expected 4", accepts);
    end
    for (int k = 0; k < 5; k++) begin
      sample_point();
      vectors++;
      if (k < 4 && (mem_we !== 1'b1 || mem_addr !== 17'd5 || mem_wdata !== 16'hABCD)) begin
        miscompares++;
        $display("FAIL drain_write: slot %0d we=%b addr=%0d data=%h expected we=1 addr=5 data=abcd", k, mem_we, mem_addr, mem_wdata);
      end else if (k == 4 && mem_en !== 1'b0) begin
        miscompares++;
        $display("FAIL drain_done: mem_en=%b expected 0", mem_en);
      end
      drive_edge();
    end
    vectors++;
    if (stall_cnt !== EXP_STALL) begin
      miscompares++;
      $display("FAIL stall_cnt: got %0d expected %0d", stall_cnt, EXP_STALL);
    end
  endtask

  task automatic test_clear();
    bit last_seen = 0, done = 0;
    drive_edge(); clr_req = 1; wr_valid = 1; wr_addr = 17'd3; wr_data = 16'h0303;
    exp_clr_active = 1; exp_clr_addr = '0;
    drive_edge(); clr_req = 0; wr_valid = 0;
    sample_point();
    vectors++;
    if (clr_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_busy_rise: got %b expected 1", clr_busy);
    end
    for (int c = 0; c < 4 * TB_DEPTH && !done; c++) begin
      drive_edge();
      rd_pre = c[0]; clr_req = (c == 40); wr_valid = (c == 20);
      wr_addr = 17'd9; wr_data = 16'h1234;
      sample_point();
      vectors++;
      if (last_seen) begin
        done = 1;
        if (clr_busy !== 1'b0) begin
          miscompares++;
          $display("FAIL clr_busy_fall: got %b expected 0", clr_busy);
        end
      end else if (clr_busy !== 1'b1) begin
        miscompares++;
        $display("FAIL clr_busy_hold: cycle %0d got %b expected 1", c, clr_busy);
      end
      last_seen = !exp_clr_active;
    end
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL clear_timeout: clr_busy=%b expected clear to finish", clr_busy);
    end
    drive_edge(); idle_inputs();
    repeat (6) drive_edge();
    vectors++;
    if (wr_q.size() != 0) begin
      miscompares++;
      $display("FAIL post_clear_writes: %0d pending expected 0", wr_q.size());
    end
  endtask

  task automatic test_drop_out_of_range();
    int en_cnt = 0;
    drive_edge(); wr_valid = 1; wr_addr = 17'(TB_DEPTH); wr_data = 16'hBEEF;
    drive_edge(); wr_addr = 17'd7; wr_data = 16'h0777;
    sample_point();
    vectors++;
    if (mem_en !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_access: mem_en=%b expected 0", mem_en);
    end
    drive_edge(); wr_valid = 0;
    sample_point();
    vectors++;
    if (mem_we !== 1'b1 || mem_addr !== 17'd7 || mem_wdata !== 16'h0777) begin
      miscompares++;
      $display("FAIL keep_write: we=%b addr=%0d data=%h expected we=1 addr=7 data=0777", mem_we, mem_addr, mem_wdata);
    end
    for (int k = 0; k < 4; k++) begin
      drive_edge(); sample_point();
      if (mem_en === 1'b1) en_cnt++;
    end
    vectors++;
    if (en_cnt != 0) begin
      miscompares++;
      $display("FAIL drop_quiet: %0d accesses expected 0", en_cnt);
    end
  endtask

  task automatic test_reset_mid_clear();
    int en_cnt = 0;
    drive_edge(); clr_req = 1; exp_clr_active = 1; exp_clr_addr = '0;
    drive_edge(); clr_req = 0;
    for (int k = 0; k < 3; k++) begin
      drive_edge(); wr_valid = 1; wr_addr = 17'(20 + k); wr_data = 16'(k);
    end
    drive_edge(); wr_valid = 0;
    repeat (8) drive_edge();
    mon_on = 0; Reset_n = 0;
    #1;
    vectors++;
    if (clr_busy !== 1'b0 || wr_ready !== 1'b1 || mem_en !== 1'b0 || stall_cnt !== 16'h0) begin
      miscompares++;
      $display("FAIL mid_reset: busy=%b ready=%b en=%b stall=%0d expected 0 1 0 0", clr_busy, wr_ready, mem_en, stall_cnt);
    end
    repeat (2) drive_edge();
    Reset_n = 1; flush_model(); mon_on = 1;
    for (int k = 0; k < 10; k++) begin
      drive_edge(); sample_point();
      if (mem_en === 1'b1) en_cnt++;
    end
    vectors++;
    if (en_cnt != 0 || clr_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_quiet: accesses=%0d busy=%b expected 0 0", en_cnt, clr_busy);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read_burst();
    test_wrap_and_frame_start();
    test_write_stall();
    test_clear();
    test_drop_out_of_range();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
